avalon_sample_slave: RTL and testbench
======================================

AVALON_SAMPLE_SLAVE -- requirements
Module: avalon_sample_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample and register data width.
REQ-002 SHALL have parameter NUM_SAMPLES, default 256, meaning FFT frame length; power of two, 8..1024.
REQ-003 SHALL have parameter ADDR_W, default 9, meaning Avalon word-address width; must be >= clog2(NUM_SAMPLES)+1.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port n_rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports slave_chipselect, slave_read and slave_write, each input, 1, meaning Avalon-MM slave strobes.
REQ-007 SHALL have port slave_address, input, ADDR_W, meaning word address.
REQ-008 SHALL have port slave_writedata, input, DATA_W, meaning write data.
REQ-009 SHALL have port slave_readdata, output, DATA_W, meaning read data.
REQ-010 SHALL have port slave_readdatavalid, output, 1, meaning read data qualifier.
REQ-011 SHALL have port sWriteEn, output, 1, meaning sample-buffer write strobe.
REQ-012 SHALL have port wAddress, output, clog2(NUM_SAMPLES), meaning sample-buffer index.
REQ-013 SHALL have port fft_init_data, output, DATA_W, meaning sample-buffer write data.
REQ-014 SHALL have port fft_start, output, 1, meaning one-cycle FFT start pulse.
REQ-015 SHALL have ports fft_busy and fft_done, each input, 1; fft_done is a one-cycle completion pulse from the core.
REQ-016 SHALL have port irq, output, 1, meaning level interrupt.

Function
REQ-017 Access SHALL be ignored unless slave_chipselect=1; if read and write are both high, write wins and no read is performed.
REQ-018 Address map SHALL be: 0..NUM_SAMPLES-1 = sample window; NUM_SAMPLES = CTRL; NUM_SAMPLES+1 = STATUS; NUM_SAMPLES+2 = COUNT; any higher address is ignored on write and reads 0.
REQ-019 CTRL bits SHALL be: b0 START (self-clearing), b1 AUTO_START (sticky), b2 CLEAR (self-clearing), b3 IRQ_EN (sticky).
REQ-020 STATUS bits SHALL be: [2:0] state code, b3 DONE, b4 ERR, b5 FULL (count==NUM_SAMPLES).
REQ-021 Reads SHALL have 1-cycle latency, with slave_readdatavalid high for exactly one cycle; sample-window reads return 0.
REQ-022 FSM states SHALL be IDLE=0, LOAD=1, START=2, RUN=3, DONE=4.
REQ-023 In IDLE or LOAD, an accepted sample write SHALL drive sWriteEn=1, wAddress=address and fft_init_data=writedata on the next cycle for exactly one cycle; IDLE moves to LOAD.
REQ-024 COUNT SHALL increment per accepted sample write and saturate at NUM_SAMPLES; overwrites at saturation are still forwarded.
REQ-025 In LOAD, a move to START SHALL occur on FULL with AUTO_START=1, or on a START write while FULL; a START write while not FULL sets ERR and causes no transition.
REQ-026 In START, fft_start SHALL be 1 for exactly one cycle, then the FSM moves to RUN.
REQ-027 In RUN, sample writes SHALL be dropped (sWriteEn stays 0) and set ERR; fft_done moves the FSM to DONE and sets DONE.
REQ-028 A sample write coincident with fft_done SHALL be dropped and set ERR.
REQ-029 A CLEAR write in LOAD or DONE SHALL return to IDLE, zero COUNT, and clear DONE and ERR; CLEAR in START or RUN is ignored.
REQ-030 A START write outside LOAD SHALL be ignored without setting ERR.
REQ-031 fft_busy SHALL be readable only as STATUS b6 and SHALL NOT affect transitions.

Reset
REQ-032 On n_rst=0, all outputs SHALL be 0 and the FSM, CTRL, COUNT, DONE and ERR SHALL be reset to IDLE/0 asynchronously, including mid-frame.
REQ-033 Release of n_rst SHALL be synchronised internally; the first access is accepted on the second rising edge after release.

Configuration
REQ-034 With AVALON_SAMPLE_SLAVE_IRQ_EN defined, irq SHALL equal DONE AND IRQ_EN, registered.
REQ-035 Without AVALON_SAMPLE_SLAVE_IRQ_EN, irq SHALL be tied 0 and CTRL b3 SHALL read 0.

Verification
REQ-036 Write CTRL=0x0002, then 256 sample writes with data=index -> 256 sWriteEn pulses, wAddress/data=index; one fft_start pulse one cycle after FULL; STATUS=0x0022.
REQ-037 Write 10 samples, then CTRL=0x0001 -> STATUS ERR=1, state LOAD, no fft_start; COUNT reads 10.
REQ-038 In RUN, write sample addr 5 data 0xABCD -> no sWriteEn, ERR=1; pulse fft_done -> STATUS DONE=1, state 4.
REQ-039 Macro defined, CTRL=0x000A, full frame, fft_done -> irq=1; CTRL=0x0004 -> irq=0, state IDLE, COUNT=0.
REQ-040 Assert n_rst=0 after 100 sample writes -> all outputs 0, COUNT=0; read STATUS=0x0000 with readdatavalid one cycle after read.

Source files
------------

// File: rtl/avalon_sample_slave.sv
// Avalon-MM front end that loads an FFT sample frame and sequences the FFT core.
// Define AVALON_SAMPLE_SLAVE_IRQ_EN to enable CTRL.IRQ_EN and the irq output.
module avalon_sample_slave #(
    parameter int DATA_W      = 16,
    parameter int NUM_SAMPLES = 256,
    parameter int ADDR_W      = 9
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           slave_chipselect,
    input  logic                           slave_read,
    input  logic                           slave_write,
    input  logic [ADDR_W-1:0]              slave_address,
    input  logic [DATA_W-1:0]              slave_writedata,
    output logic [DATA_W-1:0]              slave_readdata,
    output logic                           slave_readdatavalid,
    output logic                           sWriteEn,
    output logic [$clog2(NUM_SAMPLES)-1:0] wAddress,
    output logic [DATA_W-1:0]              fft_init_data,
    output logic                           fft_start,
    input  logic                           fft_busy,
    input  logic                           fft_done,
    output logic                           irq
);

    localparam int AW = $clog2(NUM_SAMPLES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     FULL_CNT = CW'(NUM_SAMPLES);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_SAMPLES);
    localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(NUM_SAMPLES + 1);
    localparam logic [ADDR_W-1:0] A_CNT    = ADDR_W'(NUM_SAMPLES + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                live_q;
    logic [CW-1:0]       count_q, count_d;
    logic                auto_q, auto_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                swe_q, swe_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                irq_q, irq_d;

    logic wr, rd, done_in, is_smp, is_ctrl, full, go, clr;

    // live_q gates the bus until one edge after reset release
    assign wr      = live_q & slave_chipselect & slave_write;
    assign rd      = live_q & slave_chipselect & slave_read & ~slave_write;
    assign done_in = live_q & fft_done;
    assign is_smp  = slave_address < A_CTRL;
    assign is_ctrl = slave_address == A_CTRL;
    assign full    = count_q == FULL_CNT;
    assign go      = wr & is_ctrl & slave_writedata[0];
    assign clr     = wr & is_ctrl & slave_writedata[2];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        err_d    = err_q;
        swe_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rvalid_d = rd;
        rdata_d  = '0;

        if (wr && is_ctrl) begin
            auto_d = slave_writedata[1];
`ifdef AVALON_SAMPLE_SLAVE_IRQ_EN
            irq_en_d = slave_writedata[3];
`endif
        end

        if (wr && is_smp) begin
            if (!done_in && (state_q == S_IDLE || state_q == S_LOAD)) begin
                swe_d   = 1'b1;
                waddr_d = slave_address[AW-1:0];
                wdata_d = slave_writedata;
                if (!full) count_d = count_q + 1'b1;
                if (state_q == S_IDLE) state_d = S_LOAD;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (clr) begin
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (clr) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (full && (auto_q || go)) begin
                    state_d = S_START;
                end else if (go) begin
                    err_d = 1'b1;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (done_in) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (clr) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        start_d = state_d == S_START;

        if (rd) begin
            if (is_ctrl) begin
                rdata_d[1] = auto_q;
                rdata_d[3] = irq_en_q;
            end else if (slave_address == A_STAT) begin
                rdata_d[2:0] = state_q;
                rdata_d[3]   = done_q;
                rdata_d[4]   = err_q;
                rdata_d[5]   = full;
                rdata_d[6]   = fft_busy;
            end else if (slave_address == A_CNT) begin
                rdata_d = DATA_W'(count_q);
            end
        end

`ifdef AVALON_SAMPLE_SLAVE_IRQ_EN
        irq_d = done_d & irq_en_d;
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            live_q   <= 1'b0;
            state_q  <= S_IDLE;
            count_q  <= '0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            swe_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            start_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            live_q   <= 1'b1;
            state_q  <= state_d;
            count_q  <= count_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            swe_q    <= swe_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            start_q  <= start_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign slave_readdata      = rdata_q;
    assign slave_readdatavalid = rvalid_q;
    assign sWriteEn            = swe_q;
    assign wAddress            = waddr_q;
    assign fft_init_data       = wdata_q;
    assign fft_start           = start_q;
    assign irq                 = irq_q;

endmodule

// File: tb/tb_avalon_sample_slave.sv
// Bench for avalon_sample_slave: frame-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_avalon_sample_slave;

    localparam int N  = 256;
    localparam int AW = 8;
`ifdef AVALON_SAMPLE_SLAVE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_RUN = 3, P_DONE = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cs = 1'b0, re = 1'b0, we = 1'b0;
    logic [8:0]  addr = '0;
    logic [15:0] wd = '0;
    logic [15:0] slave_readdata;
    logic        slave_readdatavalid;
    logic        sWriteEn;
    logic [AW-1:0] wAddress;
    logic [15:0] fft_init_data;
    logic        fft_start;
    logic        fft_busy = 1'b0;
    logic        fft_done = 1'b0;
    logic        irq;

    avalon_sample_slave dut (
        .clk(clk), .n_rst(n_rst),
        .slave_chipselect(cs), .slave_read(re), .slave_write(we),
        .slave_address(addr), .slave_writedata(wd),
        .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid),
        .sWriteEn(sWriteEn), .wAddress(wAddress),
        .fft_init_data(fft_init_data), .fft_start(fft_start),
        .fft_busy(fft_busy), .fft_done(fft_done), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 0;
    int cyc = 0;
    int swe_cnt = 0, start_cnt = 0, last_swe_cyc = 0, start_cyc = 0;
    int last_wa = 0, last_wd = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // reference model: frame bookkeeping plus expected registered outputs
    int  m_phase, m_count;
    bit  m_auto, m_irqen, m_done, m_err, m_live;
    bit  e_swe, e_start, e_rv, e_irq;
    int  e_wa, e_wd, e_rd;

    function automatic int read_word(int a);
        if (a == N)     return (int'(m_auto) << 1) | (int'(m_irqen) << 3);
        if (a == N + 1) return m_phase | (int'(m_done) << 3) | (int'(m_err) << 4)
                               | (int'(m_count == N) << 5) | (int'(fft_busy) << 6);
        if (a == N + 2) return m_count;
        return 0;
    endfunction

    task automatic wipe_frame();
        m_phase = P_IDLE; m_count = 0; m_done = 0; m_err = 0;
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wipe_frame();
            m_auto = 0; m_irqen = 0; m_live = 0;
            e_swe = 0; e_start = 0; e_rv = 0; e_irq = 0;
            e_wa = 0; e_wd = 0; e_rd = 0;
        end else if (!m_live) begin
            m_live = 1;
        end else begin
            automatic bit w     = cs && we;
            automatic bit r     = cs && re && !we;
            automatic bit dn    = fft_done;
            automatic int a     = int'(addr);
            automatic int ph    = m_phase;
            automatic bit was_full = (m_count == N);
            automatic bit old_auto = m_auto;
            automatic bit c_go  = w && a == N && wd[0];
            automatic bit c_clr = w && a == N && wd[2];
            e_swe = 0;
            e_rv  = r;
            e_rd  = r ? read_word(a) : 0;
            if (w && a == N) begin
                m_auto = wd[1];
                if (IRQ_ON) m_irqen = wd[3];
            end
            if (w && a < N) begin
                if (!dn && (ph == P_IDLE || ph == P_LOAD)) begin
                    e_swe = 1; e_wa = a; e_wd = int'(wd);
                    m_count = (m_count < N) ? m_count + 1 : N;
                    m_phase = P_LOAD;
                end else m_err = 1;
            end
            if (ph == P_LOAD && c_clr) wipe_frame();
            else if ((ph == P_IDLE || ph == P_DONE) && c_clr) wipe_frame();
            else if (ph == P_LOAD && was_full && (old_auto || c_go)) m_phase = P_START;
            else if (ph == P_LOAD && c_go) m_err = 1;
            else if (ph == P_START) m_phase = P_RUN;
            else if (ph == P_RUN && dn) begin m_phase = P_DONE; m_done = 1; end
            e_start = (m_phase == P_START);
            e_irq   = m_done && m_irqen;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sWriteEn", 32'(sWriteEn), 32'(e_swe));
            chk("fft_start", 32'(fft_start), 32'(e_start));
            chk("readdatavalid", 32'(slave_readdatavalid), 32'(e_rv));
            chk("irq", 32'(irq), 32'(e_irq));
            if (e_swe) begin
                chk("wAddress", 32'(wAddress), e_wa);
                chk("fft_init_data", 32'(fft_init_data), e_wd);
            end
            if (e_rv) chk("readdata", 32'(slave_readdata), e_rd);
            if (sWriteEn) begin
                swe_cnt++; last_swe_cyc = cyc;
                last_wa = int'(wAddress); last_wd = int'(fft_init_data);
            end
            if (fft_start) begin start_cnt++; start_cyc = cyc; end
        end
    end

    task automatic bus_wr(input int a, input int d);
        cs = 1; we = 1; re = 0; addr = 9'(a); wd = 16'(d);
        @(posedge clk); #1;
        cs = 0; we = 0;
    endtask

    task automatic bus_rd(input int a, output int d);
        cs = 1; re = 1; we = 0; addr = 9'(a);
        @(posedge clk); #1;
        cs = 0; re = 0;
        chk("rvalid_after_read", 32'(slave_readdatavalid), 32'd1);
        d = int'(slave_readdata);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_done();
        fft_done = 1; @(posedge clk); #1; fft_done = 0;
    endtask

    initial begin
        int d, s0, st0;
        @(posedge clk); #1;
        chk_en = 1;
        idle(2);
        chk("rst_swe", 32'(sWriteEn), 0);
        chk("rst_start", 32'(fft_start), 0);
        chk("rst_rdata", 32'(slave_readdata), 0);
        chk("rst_irq", 32'(irq), 0);
        n_rst = 1;
        idle(2);

        // auto-start full frame
        s0 = swe_cnt; st0 = start_cnt;
        bus_wr(N, 2);
        for (int i = 0; i < N; i++) bus_wr(i, i);
        idle(1);
        bus_rd(N + 1, d);
        chk("frame_status", d, 32'h22);
        chk("frame_swe_pulses", swe_cnt - s0, N);
        chk("frame_start_pulses", start_cnt - st0, 1);
        chk("start_after_full", start_cyc - last_swe_cyc, 1);
        chk("last_waddr", last_wa, 255);
        chk("last_wdata", last_wd, 255);

        // write while running, then completion
        fft_busy = 1;
        s0 = swe_cnt;
        bus_wr(5, 16'hABCD);
        idle(1);
        chk("run_drop_swe", swe_cnt - s0, 0);
        bus_rd(N + 1, d);
        chk("run_status", d, 32'h73);
        fft_busy = 0;
        pulse_done();
        bus_rd(N + 1, d);
        chk("done_status", d, 32'h3C);
        bus_rd(N, d);
        chk("ctrl_readback", d, 32'h2);
        bus_wr(N, 4);
        bus_rd(N + 1, d);
        chk("clear_status", d, 0);

        // start while not full
        st0 = start_cnt;
        for (int i = 0; i < 10; i++) bus_wr(i, 100 + i);
        bus_wr(N, 1);
        idle(2);
        bus_rd(N + 1, d);
        chk("early_start_status", d, 32'h11);
        bus_rd(N + 2, d);
        chk("early_count", d, 10);
        chk("early_no_start", start_cnt - st0, 0);
        bus_rd(3, d);
        chk("window_read", d, 0);
        bus_rd(N + 3, d);
        chk("high_read", d, 0);
        bus_wr(N, 4);

        // interrupt path
        bus_wr(N, 32'hA);
        bus_rd(N, d);
        chk("ctrl_irqen_bit", d, IRQ_ON ? 32'hA : 32'h2);
        for (int i = 0; i < N; i++) bus_wr(i, 16'h5000 + i);
        idle(3);
        pulse_done();
        chk("irq_set", 32'(irq), 32'(IRQ_ON));
        bus_wr(N, 4);
        chk("irq_clear", 32'(irq), 0);
        bus_rd(N + 1, d);
        chk("irq_clr_status", d, 0);
        bus_rd(N + 2, d);
        chk("irq_clr_count", d, 0);

        // asynchronous reset mid-frame
        for (int i = 0; i < 100; i++) bus_wr(i, 16'hBEEF);
        chk("pre_rst_swe", 32'(sWriteEn), 1);
        n_rst = 0;
        #1;
        chk("arst_swe", 32'(sWriteEn), 0);
        chk("arst_waddr", 32'(wAddress), 0);
        chk("arst_wdata", 32'(fft_init_data), 0);
        chk("arst_rv", 32'(slave_readdatavalid), 0);
        chk("arst_irq", 32'(irq), 0);
        idle(2);
        n_rst = 1;
        bus_wr(N, 2);
        bus_rd(N, d);
        chk("first_edge_ignored", d, 0);
        bus_rd(N + 1, d);
        chk("arst_status", d, 0);
        bus_rd(N + 2, d);
        chk("arst_count", d, 0);

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            automatic int sel = $urandom_range(0, 9);
            automatic int a;
            automatic int dd = $urandom_range(0, 16'hFFFF);
            if (sel <= 5)      a = $urandom_range(0, N - 1);
            else if (sel == 9) a = $urandom_range(N + 3, 511);
            else               a = N + (sel - 6);
            if (a == N) begin
                dd = $urandom_range(0, 15);
                if (dd[2] && $urandom_range(0, 3) != 0) dd[2] = 0;
            end
            cs = ($urandom_range(0, 4) != 0);
            we = $urandom_range(0, 1);
            re = $urandom_range(0, 1);
            addr = 9'(a); wd = 16'(dd);
            fft_done = ($urandom_range(0, 29) == 0);
            fft_busy = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        cs = 0; we = 0; re = 0; fft_done = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
